// File: rtl/clk_ctrl_pkg.sv
// Shared types and default widths for the CPU clock run/halt/step sequencer.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        BURST  = 2'd3
    } clk_state_e;

    localparam int BURST_W_DEF = 8;
    localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/clk_ctrl_edge_rise.sv
// One-bit rising-edge detector; history resets high so a level held through reset never fires.
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= din;
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/clk_ctrl.sv
// Run/halt/step/burst sequencer producing the registered CPU clock enable
// and a saturating count of enabled cycles.
//
//  state  | meaning
//  HALTED | clock gated off, waiting for a command
//  RUN    | free-running until halt_i or cpu_hlt_i
//  STEP   | single enabled cycle, then HALTED with done
//  BURST  | cnt enabled cycles, then HALTED with done
module clk_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int BURST_W   = BURST_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter bit RESET_RUN = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_i,
    input  logic               halt_i,
    input  logic               step_i,
    input  logic               burst_i,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic               cpu_hlt_i,
    input  logic               cnt_clr_i,
    output logic               clk_en_o,
    output logic [1:0]         state_o,
    output logic [CNT_W-1:0]   cycles_o,
    output logic               done_o
);

    clk_state_e         state_q, state_nxt;
    logic [BURST_W-1:0] cnt_q, cnt_nxt;
    logic               done_q, done_nxt;
    logic               en_q;
    logic               first_q;
    logic [CNT_W-1:0]   cycles_q;
    logic               run_rise, step_rise, burst_rise;
    logic               run_req, stop;

    edge_rise u_run_edge   (.clk(clk), .rst_n(rst_n), .din(run_i),   .rise(run_rise));
    edge_rise u_step_edge  (.clk(clk), .rst_n(rst_n), .din(step_i),  .rise(step_rise));
    edge_rise u_burst_edge (.clk(clk), .rst_n(rst_n), .din(burst_i), .rise(burst_rise));

    // The first cycle after reset release acts as a run edge when RESET_RUN is set.
    assign run_req = run_rise | (RESET_RUN & first_q);
    assign stop    = halt_i | cpu_hlt_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HALTED;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            done_q  <= done_nxt;
            en_q    <= (state_nxt != HALTED);
            first_q <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        done_nxt  = 1'b0;
        case (state_q)
            HALTED: begin
                if (!stop) begin
                    if (run_req) begin
                        state_nxt = RUN;
                    end else if (burst_rise) begin
                        if (burst_len_i != '0) begin
                            state_nxt = BURST;
                            cnt_nxt   = burst_len_i;
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end else if (step_rise) begin
                        state_nxt = STEP;
                    end
                end
            end
            RUN: begin
                if (stop) state_nxt = HALTED;
            end
            STEP: begin
                state_nxt = HALTED;
                done_nxt  = ~stop;
            end
            BURST: begin
                if (stop) begin
                    state_nxt = HALTED;
                    cnt_nxt   = '0;
                end else if (run_req) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else if (cnt_q == BURST_W'(1)) begin
                    state_nxt = HALTED;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt_q - BURST_W'(1);
                end
            end
            default: begin
                state_nxt = HALTED;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Clear takes precedence over the increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cycles_q <= '0;
        else if (cnt_clr_i)
            cycles_q <= '0;
        else if (en_q && (cycles_q != {CNT_W{1'b1}}))
            cycles_q <= cycles_q + CNT_W'(1);
    end

    always_comb begin
        clk_en_o = en_q;
        done_o   = done_q;
        state_o  = state_q;
        cycles_o = cycles_q;
    end

endmodule

// File: tb/tb_clk_ctrl.sv
// Directed bench for clk_ctrl: per-cycle expectations queued with each stimulus and
// popped one per clock; a second instance covers counter saturation and RESET_RUN.
module tb_clk_ctrl;

    localparam logic [1:0] S_HALT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STEP  = 2'd2;
    localparam logic [1:0] S_BURST = 2'd3;

    typedef struct {
        logic       en;
        logic       done;
        logic [1:0] st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, run_i, halt_i, step_i, burst_i, cpu_hlt_i, cnt_clr_i;
    logic [7:0]  burst_len_i;
    logic        clk_en_o, done_o;
    logic [1:0]  state_o;
    logic [15:0] cycles_o;

    logic        s_rst_n, s_halt, s_clr;
    logic        s_en, s_done;
    logic [1:0]  s_state;
    logic [3:0]  s_cycles;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   model_cyc = 0;

    always #5 clk = ~clk;

    clk_ctrl #(.BURST_W(8), .CNT_W(16), .RESET_RUN(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .run_i(run_i), .halt_i(halt_i), .step_i(step_i),
        .burst_i(burst_i), .burst_len_i(burst_len_i), .cpu_hlt_i(cpu_hlt_i),
        .cnt_clr_i(cnt_clr_i), .clk_en_o(clk_en_o), .state_o(state_o),
        .cycles_o(cycles_o), .done_o(done_o)
    );

    clk_ctrl #(.BURST_W(8), .CNT_W(4), .RESET_RUN(1'b1)) u_sat (
        .clk(clk), .rst_n(s_rst_n), .run_i(1'b0), .halt_i(s_halt), .step_i(1'b0),
        .burst_i(1'b0), .burst_len_i(8'd0), .cpu_hlt_i(1'b0),
        .cnt_clr_i(s_clr), .clk_en_o(s_en), .state_o(s_state),
        .cycles_o(s_cycles), .done_o(s_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic expect_n(input int n, input logic en, input logic done, input logic [1:0] st);
        exp_t e;
        e.en = en;
        e.done = done;
        e.st = st;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (q.size() != 0) begin
            e = q.pop_front();
            tick();
            chk({tag, ".clk_en"}, 32'(clk_en_o), 32'(e.en));
            chk({tag, ".done"},   32'(done_o),   32'(e.done));
            chk({tag, ".state"},  32'(state_o),  32'(e.st));
            if (e.en) model_cyc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; run_i = 1'b1; halt_i = 1'b0; step_i = 1'b1; burst_i = 1'b1;
        cpu_hlt_i = 1'b0; cnt_clr_i = 1'b0; burst_len_i = 8'd3;
        s_rst_n = 1'b0; s_halt = 1'b1; s_clr = 1'b0;

        // reset with commands held high: nothing may fire on release
        tick(); tick();
        chk("rst.clk_en", 32'(clk_en_o), 32'd0);
        chk("rst.state",  32'(state_o),  32'(S_HALT));
        rst_n = 1'b1;
        expect_n(3, 1'b0, 1'b0, S_HALT);
        drain("rst_release");
        chk("rst.cycles", 32'(cycles_o), 32'd0);
        run_i = 1'b0; step_i = 1'b0; burst_i = 1'b0;
        tick();

        // single step
        step_i = 1'b1;
        expect_n(1, 1'b1, 1'b0, S_STEP);
        expect_n(1, 1'b0, 1'b1, S_HALT);
        expect_n(2, 1'b0, 1'b0, S_HALT);
        drain("step");
        step_i = 1'b0;
        chk("step.cycles", 32'(cycles_o), 32'(model_cyc));

        // burst of 5
        burst_len_i = 8'd5;
        burst_i = 1'b1;
        expect_n(5, 1'b1, 1'b0, S_BURST);
        expect_n(1, 1'b0, 1'b1, S_HALT);
        expect_n(1, 1'b0, 1'b0, S_HALT);
        drain("burst5");
        burst_i = 1'b0;
        chk("burst5.cycles", 32'(cycles_o), 32'(model_cyc));
        tick();

        // zero-length burst: only a done pulse
        burst_len_i = 8'd0;
        burst_i = 1'b1;
        expect_n(1, 1'b0, 1'b1, S_HALT);
        expect_n(2, 1'b0, 1'b0, S_HALT);
        drain("burst0");
        burst_i = 1'b0;
        chk("burst0.cycles", 32'(cycles_o), 32'(model_cyc));
        tick();

        // free run stopped by the CPU HLT flag
        run_i = 1'b1;
        expect_n(11, 1'b1, 1'b0, S_RUN);
        drain("run");
        cpu_hlt_i = 1'b1;
        expect_n(2, 1'b0, 1'b0, S_HALT);
        drain("run_hlt");
        chk("run.cycles", 32'(cycles_o), 32'(model_cyc));
        run_i = 1'b0;
        tick();
        run_i = 1'b1; step_i = 1'b1;
        expect_n(3, 1'b0, 1'b0, S_HALT);
        drain("hlt_blocks");
        cpu_hlt_i = 1'b0;
        expect_n(3, 1'b0, 1'b0, S_HALT);
        drain("no_queue");
        run_i = 1'b0; step_i = 1'b0;
        tick();

        // run edge takes over a burst: no done
        burst_len_i = 8'd4;
        burst_i = 1'b1;
        expect_n(2, 1'b1, 1'b0, S_BURST);
        drain("burst_run");
        run_i = 1'b1;
        expect_n(3, 1'b1, 1'b0, S_RUN);
        drain("burst_to_run");
        halt_i = 1'b1;
        expect_n(2, 1'b0, 1'b0, S_HALT);
        drain("burst_run_halt");
        halt_i = 1'b0; run_i = 1'b0; burst_i = 1'b0;
        tick();

        // burst of 8 aborted by halt_i in its 3rd enabled cycle
        burst_len_i = 8'd8;
        burst_i = 1'b1;
        expect_n(3, 1'b1, 1'b0, S_BURST);
        drain("burst8");
        halt_i = 1'b1;
        expect_n(3, 1'b0, 1'b0, S_HALT);
        drain("burst8_abort");
        chk("abort.cycles", 32'(cycles_o), 32'(model_cyc));
        halt_i = 1'b0; burst_i = 1'b0;
        tick();

        // reset mid-burst drops the enable at once
        burst_i = 1'b1;
        expect_n(2, 1'b1, 1'b0, S_BURST);
        drain("burst_rst");
        rst_n = 1'b0;
        #1;
        model_cyc = 0;
        chk("midrst.clk_en", 32'(clk_en_o), 32'd0);
        chk("midrst.state",  32'(state_o),  32'(S_HALT));
        chk("midrst.done",   32'(done_o),   32'd0);
        chk("midrst.cycles", 32'(cycles_o), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        expect_n(3, 1'b0, 1'b0, S_HALT);
        drain("post_rst");
        burst_i = 1'b0;

        // RESET_RUN instance: halted by halt_i on release, one-shot not retained
        tick();
        s_rst_n = 1'b1;
        tick(); tick();
        chk("rr_halt.clk_en", 32'(s_en), 32'd0);
        chk("rr_halt.state",  32'(s_state), 32'(S_HALT));
        s_halt = 1'b0;
        tick(); tick();
        chk("rr_late.clk_en", 32'(s_en), 32'd0);
        s_rst_n = 1'b0;
        tick();
        s_rst_n = 1'b1;
        tick();
        chk("rr_run.clk_en", 32'(s_en), 32'd1);
        chk("rr_run.state",  32'(s_state), 32'(S_RUN));
        repeat (20) tick();
        chk("sat.cycles", 32'(s_cycles), 32'd15);
        s_clr = 1'b1;
        tick();
        chk("clr.cycles", 32'(s_cycles), 32'd0);
        s_clr = 1'b0;
        tick();
        chk("after_clr.cycles", 32'(s_cycles), 32'd1);
        chk("sat.done", 32'(s_done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
